// File: rtl/dmem_responder_pkg.sv
// Shared types for the data-memory responder: request/response records and FSM state.
package dmem_responder_pkg;

  typedef logic [31:0] u32_t;
  typedef logic [3:0]  wrstb_t;

  typedef struct packed {
    logic   we;
    u32_t   addr;
    u32_t   wdata;
    wrstb_t wstb;
  } mem_req_t;

  typedef struct packed {
    u32_t rdata;
    logic err;
  } mem_rsp_t;

  typedef enum logic [1:0] {
    DMEM_IDLE,
    DMEM_WAIT,
    DMEM_RESP
  } dmem_state_e;

endpackage

// File: rtl/dmem_responder_array.sv
// Single-port word RAM: byte-lane write enables and a registered read port.
module dmem_array
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic                           clk,
  input  logic                           re_i,
  input  wrstb_t                         we_i,
  input  logic [$clog2(DEPTH_WORDS)-1:0] idx_i,
  input  u32_t                           wdata_i,
  output u32_t                           rdata_o
);

  u32_t mem_q [DEPTH_WORDS];
  u32_t rdata_q;

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we_i[i]) mem_q[idx_i][8*i +: 8] <= wdata_i[8*i +: 8];
    end
    if (re_i) rdata_q <= mem_q[idx_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, fixed wait states, then a one-cycle response.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   req_valid,
  output logic   req_ready,
  input  logic   req_we,
  input  u32_t   req_addr,
  input  u32_t   req_wdata,
  input  wrstb_t req_wstb,
  output logic   rsp_valid,
  output u32_t   rsp_rdata,
  output logic   rsp_err
);

  localparam int unsigned AW        = $clog2(DEPTH_WORDS);
  localparam bit          NO_WAIT   = (WAIT_STATES == 0);
  localparam logic [3:0]  WAIT_INIT = NO_WAIT ? 4'd0 : 4'(WAIT_STATES - 1);

  dmem_state_e state_q;
  mem_req_t    req_q;
  logic [3:0]  wait_cnt_q;
  logic        rsp_valid_q;
  logic        rsp_err_q;
  logic        rd_sel_q;

  mem_req_t live_req;
  mem_req_t cur_req;
  u32_t     off;
  logic     accept;
  logic     cur_err;
  logic     commit;
  u32_t     ram_rdata;

  assign req_ready = (state_q == DMEM_IDLE);
  assign accept    = req_valid && req_ready;

  assign live_req = '{we: req_we, addr: req_addr, wdata: req_wdata, wstb: req_wstb};

  // With no wait states the commit edge is the accept edge, so the live request is used.
  assign cur_req = (state_q == DMEM_IDLE) ? live_req : req_q;

  // BASE_ADDR is word-aligned, so the offset's low bits are the address's low bits.
  assign off     = cur_req.addr - BASE_ADDR;
  assign cur_err = (off[1:0] != 2'b00) || (off[31:2] >= 30'(DEPTH_WORDS));

  assign commit = !rst && (((state_q == DMEM_WAIT) && (wait_cnt_q == 4'd0)) ||
                           (NO_WAIT && accept));

  dmem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clk     (clk),
    .re_i    (commit && !cur_req.we && !cur_err),
    .we_i    ((commit && cur_req.we && !cur_err) ? cur_req.wstb : 4'b0000),
    .idx_i   (off[AW+1:2]),
    .wdata_i (cur_req.wdata),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= DMEM_IDLE;
      wait_cnt_q  <= 4'd0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rd_sel_q    <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        DMEM_IDLE: begin
          if (accept) begin
            req_q      <= live_req;
            wait_cnt_q <= WAIT_INIT;
            state_q    <= NO_WAIT ? DMEM_RESP : DMEM_WAIT;
          end
        end
        DMEM_WAIT: begin
          if (wait_cnt_q == 4'd0) state_q <= DMEM_RESP;
          else wait_cnt_q <= wait_cnt_q - 4'd1;
        end
        DMEM_RESP: state_q <= DMEM_IDLE;
        default:   state_q <= DMEM_IDLE;
      endcase
      if (commit) begin
        rsp_valid_q <= 1'b1;
        rsp_err_q   <= cur_err;
        rd_sel_q    <= !cur_req.we && !cur_err;
      end
    end
  end

  // Read data lives in the RAM's output register; stores and errors report zero.
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rd_sel_q ? ram_rdata : 32'h0;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder with three instances (WAIT_STATES = 1, 0, 3).
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  localparam int ND = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        req_valid [ND];
  logic        req_ready [ND];
  logic        req_we    [ND];
  logic [31:0] req_addr  [ND];
  logic [31:0] req_wdata [ND];
  logic [3:0]  req_wstb  [ND];
  logic        rsp_valid [ND];
  logic [31:0] rsp_rdata [ND];
  logic        rsp_err   [ND];

  for (genvar g = 0; g < ND; g++) begin : g_dut
    dmem_responder #(
      .DEPTH_WORDS (1024),
      .WAIT_STATES (g == 0 ? 1 : (g == 1 ? 0 : 3)),
      .BASE_ADDR   (32'h0000_0000)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_we    (req_we[g]),
      .req_addr  (req_addr[g]),
      .req_wdata (req_wdata[g]),
      .req_wstb  (req_wstb[g]),
      .rsp_valid (rsp_valid[g]),
      .rsp_rdata (rsp_rdata[g]),
      .rsp_err   (rsp_err[g])
    );
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstb;
  } treq_t;

  exp_t        sb [$];
  logic [31:0] mdl [bit [33:0]];
  int checks = 0;
  int errors = 0;

  function automatic int ws_of(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 0 : 3);
  endfunction

  // Reference memory: 1024 words at base 0, so the legal range is 0x0..0xFFF.
  function automatic exp_t model(input int d, input logic we, input logic [31:0] a,
                                 input logic [31:0] w, input logic [3:0] s);
    exp_t        e;
    bit   [33:0] k;
    logic [31:0] m;
    e.err   = (a[1:0] != 2'b00) || (a >= 32'h0000_1000);
    e.rdata = 32'h0;
    k       = {d[1:0], a};
    if (!e.err) begin
      if (we) begin
        m = mdl.exists(k) ? mdl[k] : 32'h0;
        for (int i = 0; i < 4; i++) if (s[i]) m[8*i +: 8] = w[8*i +: 8];
        mdl[k] = m;
      end else begin
        e.rdata = mdl.exists(k) ? mdl[k] : 32'h0;
      end
    end
    return e;
  endfunction

  task automatic do_req(input int d, input logic we, input logic [31:0] a,
                        input logic [31:0] w, input logic [3:0] s, input string nm);
    int   n;
    exp_t e;
    @(negedge clk);
    req_valid[d] = 1'b1; req_we[d] = we; req_addr[d] = a; req_wdata[d] = w; req_wstb[d] = s;
    n = 0;
    while (req_ready[d] !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) begin
      checks++; errors++;
      $display("FAIL %s accept timeout", nm);
      req_valid[d] = 1'b0;
      return;
    end
    sb.push_back(model(d, we, a, w, s));
    @(posedge clk); #1;
    // Scramble the request bus: the DUT must use what it captured.
    req_valid[d] = 1'b0; req_we[d] = ~we; req_addr[d] = $urandom;
    req_wdata[d] = $urandom; req_wstb[d] = 4'hF;
    n = 0;
    do begin @(negedge clk); n++; end while (rsp_valid[d] !== 1'b1 && n < 20);
    checks++;
    if (n != ws_of(d) + 1) begin
      errors++;
      $display("FAIL %s latency got %0d want %0d", nm, n, ws_of(d) + 1);
    end
    if (rsp_valid[d] === 1'b1) begin
      e = sb.pop_front();
      checks++;
      if (rsp_rdata[d] !== e.rdata) begin
        errors++; $display("FAIL %s rdata got %h want %h", nm, rsp_rdata[d], e.rdata);
      end
      checks++;
      if (rsp_err[d] !== e.err) begin
        errors++; $display("FAIL %s err got %b want %b", nm, rsp_err[d], e.err);
      end
      checks++;
      if (req_ready[d] !== 1'b0) begin
        errors++; $display("FAIL %s ready_in_resp got %b want 0", nm, req_ready[d]);
      end
      @(negedge clk);
      checks++;
      if (rsp_valid[d] !== 1'b0 || req_ready[d] !== 1'b1) begin
        errors++;
        $display("FAIL %s after_resp valid=%b ready=%b want 0/1", nm, rsp_valid[d], req_ready[d]);
      end
    end else begin
      void'(sb.pop_front());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int d = 0; d < ND; d++) begin
      checks++;
      if (req_ready[d] !== 1'b1) begin
        errors++; $display("FAIL reset_ready[%0d] got %b want 1", d, req_ready[d]);
      end
      checks++;
      if (rsp_valid[d] !== 1'b0) begin
        errors++; $display("FAIL reset_valid[%0d] got %b want 0", d, rsp_valid[d]);
      end
      checks++;
      if (rsp_rdata[d] !== 32'h0) begin
        errors++; $display("FAIL reset_rdata[%0d] got %h want 0", d, rsp_rdata[d]);
      end
      checks++;
      if (rsp_err[d] !== 1'b0) begin
        errors++; $display("FAIL reset_err[%0d] got %b want 0", d, rsp_err[d]);
      end
    end
  endtask

  task automatic test_store_load();
    do_req(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, "st_full");
    do_req(0, 1'b0, 32'h10, 32'h0, 4'h0, "ld_full");
  endtask

  task automatic test_strobes();
    do_req(0, 1'b1, 32'h10, 32'h0000_0012, 4'b0001, "st_lane0");
    do_req(0, 1'b0, 32'h10, 32'h0, 4'h0, "ld_lane0");
    do_req(0, 1'b1, 32'h10, 32'h5555_5555, 4'b0000, "st_nostb");
    do_req(0, 1'b0, 32'h10, 32'h0, 4'h0, "ld_nostb");
    do_req(0, 1'b1, 32'h10, 32'hAA00_CC00, 4'b1010, "st_lane13");
    do_req(0, 1'b0, 32'h10, 32'h0, 4'h0, "ld_lane13");
  endtask

  task automatic test_errors();
    do_req(0, 1'b1, 32'h0,         32'hA5A5_1234, 4'hF, "st_word0");
    do_req(0, 1'b0, 32'h13,        32'h0, 4'h0, "ld_misalign");
    do_req(0, 1'b0, 32'h1000,      32'h0, 4'h0, "ld_oor");
    do_req(0, 1'b1, 32'h1000,      32'hFFFF_FFFF, 4'hF, "st_oor");
    do_req(0, 1'b0, 32'h0,         32'h0, 4'h0, "ld_word0");
    do_req(0, 1'b1, 32'hFFC,       32'h0BAD_CAFE, 4'hF, "st_last");
    do_req(0, 1'b0, 32'hFFC,       32'h0, 4'h0, "ld_last");
    do_req(0, 1'b0, 32'hFFFF_FFFC, 32'h0, 4'h0, "ld_wrap");
  endtask

  task automatic test_back_to_back();
    treq_t r [$];
    exp_t  e;
    r.push_back('{1'b1, 32'h40, 32'h0102_0304, 4'hF});
    r.push_back('{1'b0, 32'h40, 32'h0,         4'h0});
    r.push_back('{1'b1, 32'h44, 32'hCAFE_F00D, 4'hF});
    r.push_back('{1'b0, 32'h44, 32'h0,         4'h0});
    r.push_back('{1'b0, 32'h42, 32'h0,         4'h0});
    r.push_back('{1'b0, 32'h40, 32'h0,         4'h0});
    @(posedge clk); #1;
    req_valid[1] = 1'b1; req_we[1] = r[0].we; req_addr[1] = r[0].addr;
    req_wdata[1] = r[0].wdata; req_wstb[1] = r[0].wstb;
    for (int k = 0; k < r.size(); k++) begin
      @(negedge clk);
      checks++;
      if (req_ready[1] !== 1'b1 || rsp_valid[1] !== 1'b0) begin
        errors++;
        $display("FAIL b2b_idle[%0d] ready=%b valid=%b want 1/0", k, req_ready[1], rsp_valid[1]);
      end
      sb.push_back(model(1, r[k].we, r[k].addr, r[k].wdata, r[k].wstb));
      @(posedge clk); #1;
      if (k + 1 < r.size()) begin
        req_we[1] = r[k+1].we; req_addr[1] = r[k+1].addr;
        req_wdata[1] = r[k+1].wdata; req_wstb[1] = r[k+1].wstb;
      end else begin
        req_valid[1] = 1'b0;
      end
      @(negedge clk);
      checks++;
      if (rsp_valid[1] !== 1'b1 || req_ready[1] !== 1'b0) begin
        errors++;
        $display("FAIL b2b_resp[%0d] valid=%b ready=%b want 1/0", k, rsp_valid[1], req_ready[1]);
      end
      e = sb.pop_front();
      checks++;
      if (rsp_rdata[1] !== e.rdata || rsp_err[1] !== e.err) begin
        errors++;
        $display("FAIL b2b_data[%0d] got %h/%b want %h/%b", k, rsp_rdata[1], rsp_err[1], e.rdata, e.err);
      end
    end
  endtask

  task automatic test_reset_abort();
    bit seen;
    do_req(2, 1'b1, 32'h20, 32'h1122_3344, 4'hF, "abort_setup");
    @(negedge clk);
    req_valid[2] = 1'b1; req_we[2] = 1'b1; req_addr[2] = 32'h20;
    req_wdata[2] = 32'hFFFF_FFFF; req_wstb[2] = 4'hF;
    checks++;
    if (req_ready[2] !== 1'b1) begin
      errors++; $display("FAIL abort_accept got %b want 1", req_ready[2]);
    end
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (rsp_valid[2] === 1'b1) seen = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (seen) begin
      errors++; $display("FAIL abort_no_rsp got 1 want 0");
    end
    checks++;
    if (req_ready[2] !== 1'b1) begin
      errors++; $display("FAIL abort_ready got %b want 1", req_ready[2]);
    end
    do_req(2, 1'b0, 32'h20, 32'h0, 4'h0, "abort_readback");
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < ND; d++) begin
      req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = 32'h0;
      req_wdata[d] = 32'h0; req_wstb[d] = 4'h0;
    end
    test_reset();
    test_store_load();
    test_strobes();
    test_errors();
    test_back_to_back();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
